// File: rtl/frame_buf_pkg.sv
// frame_buf_pkg: shared types, constants and helpers for the N-buffer frame controller.
`default_nettype none

package frame_buf_pkg;

  typedef logic [1:0] wr_state_t;

  localparam wr_state_t ST_WRITE    = 2'd0;
  localparam wr_state_t ST_WAIT_BUF = 2'd1;
  localparam wr_state_t ST_HALT     = 2'd2;

  localparam int RST_WR_IDX  = 0;
  localparam int RST_RDY_IDX = 0;

  // Buffer index width; a 2-buffer store still needs one select bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // The reader starts on the highest buffer so it never collides with the writer's buffer 0.
  function automatic int rst_rd_idx(input int n);
    return n - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_buf_ctrl_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones.
`default_nettype none

module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] out
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign out = cnt_q;

endmodule

`default_nettype wire

// File: rtl/frame_buf_ctrl.sv
// frame_buf_ctrl: assigns writer/reader buffer indices for an N-buffer frame store,
// handing completed frames to the reader at its frame boundary.
`default_nettype none

module frame_buf_ctrl
  import frame_buf_pkg::*;
#(
  parameter int  NUM_BUFS = 3,
  parameter int  CNT_W    = 16,
  localparam int SEL_W    = sel_width(NUM_BUFS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode_single,
  input  logic             arm,
  input  logic             wr_frame_end,
  input  logic             rd_frame_end,
  output logic [SEL_W-1:0] wr_sel,
  output logic [SEL_W-1:0] rd_sel,
  output logic             wr_en,
  output logic             halted,
  output logic [CNT_W-1:0] frames_written,
  output logic [CNT_W-1:0] frames_dropped
);

  logic             wr_fe_q, rd_fe_q;
  logic             wr_ev, rd_ev;
  wr_state_t        state_q, state_d;
  logic [SEL_W-1:0] wr_idx_q, wr_idx_d;
  logic [SEL_W-1:0] rd_idx_q, rd_idx_d;
  logic [SEL_W-1:0] rdy_idx_q, rdy_idx_d;
  logic             rdy_valid_q, rdy_valid_d;
  logic             wr_en_q, halted_q;
  logic             wr_done;
  logic             any_free;
  logic [SEL_W-1:0] free_idx;

  assign wr_ev = wr_frame_end & ~wr_fe_q;
  assign rd_ev = rd_frame_end & ~rd_fe_q;

  // Writer completion is folded in before the reader flip so a same-cycle
  // reader boundary picks up the frame that just finished.
  always_comb begin
    wr_done     = wr_ev && (state_q == ST_WRITE);
    rdy_idx_d   = wr_done ? wr_idx_q : rdy_idx_q;
    rdy_valid_d = wr_done | rdy_valid_q;
    rd_idx_d    = rd_idx_q;
    if (rd_ev && rdy_valid_d) begin
      rd_idx_d    = rdy_idx_d;
      rdy_valid_d = 1'b0;
    end
  end

  // Lowest-index buffer held by neither the reader nor a pending ready frame.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int b = NUM_BUFS - 1; b >= 0; b--) begin
      if ((SEL_W'(b) != rd_idx_d) && !(rdy_valid_d && (SEL_W'(b) == rdy_idx_d))) begin
        any_free = 1'b1;
        free_idx = SEL_W'(b);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    case (state_q)
      ST_WRITE: begin
        if (wr_ev) begin
          if (mode_single) begin
            state_d = ST_HALT;
          end else if (any_free) begin
            wr_idx_d = free_idx;
          end else begin
            state_d = ST_WAIT_BUF;
          end
        end
      end
      ST_WAIT_BUF: begin
        if (any_free) begin
          state_d  = ST_WRITE;
          wr_idx_d = free_idx;
        end
      end
      ST_HALT: begin
        if (arm) begin
          if (any_free) begin
            state_d  = ST_WRITE;
            wr_idx_d = free_idx;
          end else begin
            state_d = ST_WAIT_BUF;
          end
        end
      end
      default: state_d = ST_WRITE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_fe_q     <= 1'b0;
      rd_fe_q     <= 1'b0;
      state_q     <= ST_WRITE;
      wr_idx_q    <= SEL_W'(RST_WR_IDX);
      rd_idx_q    <= SEL_W'(rst_rd_idx(NUM_BUFS));
      rdy_idx_q   <= SEL_W'(RST_RDY_IDX);
      rdy_valid_q <= 1'b0;
      wr_en_q     <= 1'b1;
      halted_q    <= 1'b0;
    end else begin
      wr_fe_q     <= wr_frame_end;
      rd_fe_q     <= rd_frame_end;
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      rdy_idx_q   <= rdy_idx_d;
      rdy_valid_q <= rdy_valid_d;
      wr_en_q     <= (state_d == ST_WRITE);
      halted_q    <= (state_d == ST_HALT);
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt_written (
    .clk   (clk),
    .reset (reset),
    .inc   (wr_done),
    .out   (frames_written)
  );

  // A frame is dropped when a new completion replaces a ready frame the reader never took.
  sat_counter #(.W(CNT_W)) u_cnt_dropped (
    .clk   (clk),
    .reset (reset),
    .inc   (wr_done && rdy_valid_q),
    .out   (frames_dropped)
  );

  assign wr_sel = wr_idx_q;
  assign rd_sel = rd_idx_q;
  assign wr_en  = wr_en_q;
  assign halted = halted_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_buf_ctrl.sv
// tb_frame_buf_ctrl: directed vector bench for a 3-buffer and a 2-buffer (2-bit counter) controller.
`default_nettype none

module tb_frame_buf_ctrl;

  typedef struct {
    logic wr;
    logic rd;
    logic ms;
    logic arm;
    int   wsel;
    int   rsel;
    int   en;
    int   hlt;
    int   fw;
    int   fd;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic       ms3 = 0, arm3 = 0, wr3 = 0, rd3 = 0;
  logic [1:0] wsel3, rsel3;
  logic       en3, hlt3;
  logic [15:0] fw3, fd3;

  logic       ms2 = 0, arm2 = 0, wr2 = 0, rd2 = 0;
  logic [0:0] wsel2, rsel2;
  logic       en2, hlt2;
  logic [1:0] fw2, fd2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  frame_buf_ctrl #(.NUM_BUFS(3), .CNT_W(16)) dut3 (
    .clk(clk), .reset(reset), .mode_single(ms3), .arm(arm3),
    .wr_frame_end(wr3), .rd_frame_end(rd3),
    .wr_sel(wsel3), .rd_sel(rsel3), .wr_en(en3), .halted(hlt3),
    .frames_written(fw3), .frames_dropped(fd3)
  );

  frame_buf_ctrl #(.NUM_BUFS(2), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .mode_single(ms2), .arm(arm2),
    .wr_frame_end(wr2), .rd_frame_end(rd2),
    .wr_sel(wsel2), .rd_sel(rsel2), .wr_en(en2), .halted(hlt2),
    .frames_written(fw2), .frames_dropped(fd2)
  );

  function automatic vec_t mk(logic wr, logic rd, logic ms, logic arm,
                              int wsel, int rsel, int en, int hlt, int fw, int fd);
    vec_t v;
    v.wr = wr; v.rd = rd; v.ms = ms; v.arm = arm;
    v.wsel = wsel; v.rsel = rsel; v.en = en; v.hlt = hlt; v.fw = fw; v.fd = fd;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk3(input string tag, input vec_t v);
    chk({tag, ".wr_sel"}, int'(wsel3), v.wsel);
    chk({tag, ".rd_sel"}, int'(rsel3), v.rsel);
    chk({tag, ".wr_en"},  int'(en3),   v.en);
    chk({tag, ".halted"}, int'(hlt3),  v.hlt);
    chk({tag, ".written"}, int'(fw3),  v.fw);
    chk({tag, ".dropped"}, int'(fd3),  v.fd);
  endtask

  task automatic chk2(input string tag, input vec_t v);
    chk({tag, ".wr_sel"}, int'(wsel2), v.wsel);
    chk({tag, ".rd_sel"}, int'(rsel2), v.rsel);
    chk({tag, ".wr_en"},  int'(en2),   v.en);
    chk({tag, ".halted"}, int'(hlt2),  v.hlt);
    chk({tag, ".written"}, int'(fw2),  v.fw);
    chk({tag, ".dropped"}, int'(fd2),  v.fd);
  endtask

  vec_t t3[$];
  vec_t t2[$];

  initial begin
    // 3 buffers: each entry is one cycle of inputs and the outputs seen one cycle later.
    //           wr rd ms arm  wsel rsel en hlt fw fd
    t3.push_back(mk(1, 0, 0, 0, 1, 2, 1, 0, 1, 0));
    t3.push_back(mk(0, 0, 0, 0, 1, 2, 1, 0, 1, 0));
    t3.push_back(mk(0, 1, 0, 0, 1, 0, 1, 0, 1, 0));
    t3.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 1, 0));
    t3.push_back(mk(1, 0, 0, 0, 2, 0, 1, 0, 2, 0));
    t3.push_back(mk(0, 0, 0, 0, 2, 0, 1, 0, 2, 0));
    t3.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0, 3, 1));
    t3.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 3, 1));
    t3.push_back(mk(0, 1, 0, 0, 1, 2, 1, 0, 3, 1));
    t3.push_back(mk(0, 0, 0, 0, 1, 2, 1, 0, 3, 1));
    t3.push_back(mk(1, 1, 0, 0, 0, 1, 1, 0, 4, 1));
    t3.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 4, 1));
    for (int k = 0; k < 5; k++)
      t3.push_back(mk(1, 0, 0, 0, 2, 1, 1, 0, 5, 1));
    t3.push_back(mk(0, 0, 0, 0, 2, 1, 1, 0, 5, 1));
    t3.push_back(mk(1, 0, 1, 0, 2, 1, 0, 1, 6, 2));
    t3.push_back(mk(0, 0, 1, 0, 2, 1, 0, 1, 6, 2));
    t3.push_back(mk(1, 0, 1, 0, 2, 1, 0, 1, 6, 2));
    t3.push_back(mk(0, 0, 1, 0, 2, 1, 0, 1, 6, 2));
    t3.push_back(mk(0, 1, 1, 0, 2, 2, 0, 1, 6, 2));
    t3.push_back(mk(0, 0, 1, 1, 0, 2, 1, 0, 6, 2));
    t3.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0, 6, 2));
    t3.push_back(mk(0, 0, 0, 1, 0, 2, 1, 0, 6, 2));

    // 2 buffers with a 2-bit written counter that saturates at 3.
    t2.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    t2.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    t2.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    t2.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    t2.push_back(mk(0, 1, 0, 0, 1, 0, 1, 0, 1, 0));
    t2.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 1, 0));
    t2.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 2, 0));
    t2.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 2, 0));
    t2.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 3, 0));
    t2.push_back(mk(0, 1, 0, 0, 1, 0, 1, 0, 3, 0));
    t2.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 3, 0));
    t2.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 3, 0));

    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk3("rst3", mk(0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
    chk2("rst2", mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0));

    foreach (t3[i]) begin
      wr3 = t3[i].wr; rd3 = t3[i].rd; ms3 = t3[i].ms; arm3 = t3[i].arm;
      @(negedge clk);
      chk3($sformatf("n3v%0d", i), t3[i]);
    end
    wr3 = 0; rd3 = 0; ms3 = 0; arm3 = 0;

    foreach (t2[i]) begin
      wr2 = t2[i].wr; rd2 = t2[i].rd; ms2 = t2[i].ms; arm2 = t2[i].arm;
      @(negedge clk);
      chk2($sformatf("n2v%0d", i), t2[i]);
    end
    wr2 = 0; rd2 = 0; ms2 = 0; arm2 = 0;

    // Mid-frame asynchronous reset: state must clear without waiting for a clock edge.
    wr3 = 1;
    #2 reset = 1'b0;
    #1;
    chk3("arst3", mk(0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
    chk2("arst2", mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    wr3 = 0;
    @(negedge clk);
    reset = 1'b1;
    wr3 = 1;
    @(negedge clk);
    chk3("post_rst", mk(0, 0, 0, 0, 1, 2, 1, 0, 1, 0));
    wr3 = 0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/frame_buf_ctrl.md
# frame_buf_ctrl

Parametrised N-buffer frame controller sitting between the camera frame writer and the pixel reader in the SDRAM/OCRAM frame store. It tracks which buffer the writer fills and which the reader scans out, handing completed frames to the reader at its frame boundary. It supports continuous capture (double/triple buffering) and single-shot capture that freezes one frame until re-armed. Outputs are buffer indices consumed by the address generators of the writer and reader.

## Interface
- NUM_BUFS, 3, number of frame buffers, legal 2..8
- CNT_W, 16, width of the statistics counters
- SEL_W (localparam), clog2(NUM_BUFS) with minimum 1, buffer index width
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-low
- mode_single  in  1  1 = single-shot capture, 0 = continuous; sampled only at writer frame end
- arm  in  1  re-arm pulse for single-shot; ignored unless halted
- wr_frame_end  in  1  writer finished current frame (pulse or level; rising edge used)
- rd_frame_end  in  1  pixel reader vsync / frame done (rising edge used)
- wr_sel  out  SEL_W  buffer index the writer must fill
- rd_sel  out  SEL_W  buffer index the reader must scan
- wr_en  out  1  writer permitted to write into wr_sel
- halted  out  1  single-shot frame captured, writer frozen
- frames_written  out  CNT_W  completed writer frames, saturating
- frames_dropped  out  CNT_W  ready frames overwritten before display, saturating

## Operation
- Edge detect: wr_ev = wr_frame_end & ~wr_frame_end_q; rd_ev likewise; the _q registers reset to 0.
- State: wr_idx, rd_idx, rdy_idx, rdy_valid, writer FSM {WRITE, WAIT_BUF, HALT}.
- Reset: wr_idx=0, rd_idx=NUM_BUFS-1, rdy_idx=0, rdy_valid=0, FSM=WRITE, wr_en=1, halted=0, counters 0.
- Writer completion (wr_ev while FSM=WRITE): frames_written++; if rdy_valid, frames_dropped++; next rdy_idx=wr_idx, rdy_valid=1.
- wr_ev while FSM≠WRITE: ignored; no counter or index change.
- Reader flip (rd_ev): if next-state rdy_valid (after applying same-cycle writer completion), rd_idx←rdy_idx, rdy_valid←0; else rd_idx unchanged, repeating the frame.
- Simultaneous wr_ev and rd_ev: writer completion applied first, so the reader takes the just-completed buffer; the previous ready buffer, if any, is counted dropped.
- Free-buffer rule: a buffer is free when it differs from next rd_idx and from next rdy_idx when next rdy_valid. The lowest-index free buffer is chosen.
- FSM WRITE, on wr_ev:
  - mode_single=1 → HALT.
  - Else, if a free buffer exists → WRITE with wr_idx = chosen free buffer.
  - Else → WAIT_BUF.
- FSM WAIT_BUF (only reachable with NUM_BUFS=2): on the first cycle a free buffer exists (after rd_ev) → WRITE with wr_idx assigned.
- FSM HALT: arm → WRITE with new free wr_idx, or WAIT_BUF if none. The reader keeps flipping, so the captured frame is displayed.
- wr_en = (FSM==WRITE); halted = (FSM==HALT).
- Counters saturate at all-ones; they are never cleared except by reset.
- Invariant: wr_idx ≠ rd_idx while wr_en=1.

## Timing
- All outputs are registered.
- An edge on an input in cycle n updates wr_sel, rd_sel, wr_en, halted and the counters at the clock edge ending cycle n; new values are visible in cycle n+1.
- Single-cycle latency from arm to wr_en.
- Minimum input pulse width: 1 cycle. A level held high counts once; a new event requires a low cycle first.
- Asynchronous reset mid-frame immediately returns all state to reset values.
- The writer must stop writing within the cycle wr_en deasserts; the block provides no backpressure beyond wr_en.

## Structure
- Package frame_buf_pkg:
  - writer FSM state typedef (WRITE, WAIT_BUF, HALT).
  - sel_width(n) function.
  - reset index constants.
- Sub-module sat_counter (parameter W; inc, out; async active-low reset) instantiated for both statistics counters.
- Free-buffer selection is a combinational priority loop over NUM_BUFS inside frame_buf_ctrl.

## Test plan
- NUM_BUFS=3, continuous: wr_ev → wr_sel 0→1, rdy=0. Then rd_ev → rd_sel 2→0, and the next wr_ev gives wr_sel=2.
- NUM_BUFS=3: two wr_ev with no rd_ev → frames_dropped=1, frames_written=2. A subsequent rd_ev loads rd_sel with the latest buffer.
- NUM_BUFS=2: wr_ev → wr_en=0 (WAIT_BUF). A later rd_ev → rd_sel=0, wr_sel=1, wr_en=1 the next cycle.
- Simultaneous wr_ev and rd_ev at NUM_BUFS=3 → rd_sel = the completed buffer, wr_sel = lowest remaining free buffer, no drop counted.
- mode_single=1:
  - wr_ev → halted=1, wr_en=0.
  - Further wr_ev pulses → no counter change.
  - arm → wr_en=1 the next cycle.
- wr_frame_end held high for 5 cycles counts once. Reset asserted mid-sequence → wr_sel=0, rd_sel=NUM_BUFS-1, counters 0.
